// File: rtl/calc_hash_pipe.sv
// calc_hash_pipe: pipelined bucket hash over a multi-word key.
// One 32-bit key word is folded into the accumulator per stage, most
// significant word first. Every stage is elastic (valid/ready). An optional
// 2-entry skid FIFO in front lets in_ready_o come straight from a flop.
module calc_hash_pipe #(
  parameter int    KEY_WIDTH      = 32,
  parameter int    BUCKET_WIDTH   = 8,
  parameter int    SIDE_WIDTH     = 32,
  parameter string HASH_TYPE      = "crc32",
  parameter int    PIPELINE_READY = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [KEY_WIDTH-1:0]    in_key_i,
  input  logic [SIDE_WIDTH-1:0]   in_side_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [KEY_WIDTH-1:0]    out_key_o,
  output logic [SIDE_WIDTH-1:0]   out_side_o,
  output logic [BUCKET_WIDTH-1:0] out_bucket_o
);

  localparam int NW       = (KEY_WIDTH >= 32) ? KEY_WIDTH / 32 : 1;
  localparam int HT_CRC   = 0;
  localparam int HT_XOR   = 1;
  localparam int HT_DUMMY = 2;
  localparam int HT       = (HASH_TYPE == "crc32")    ? HT_CRC :
                            (HASH_TYPE == "xor_fold") ? HT_XOR :
                            (HASH_TYPE == "dummy")    ? HT_DUMMY : 3;
  localparam int NS       = (32 + BUCKET_WIDTH - 1) / BUCKET_WIDTH;
  localparam int PW       = NS * BUCKET_WIDTH;

  // Parameter sanity checks, reported at elaboration.
  if (HT == 3) begin : g_err_type
    $error("calc_hash_pipe: HASH_TYPE must be crc32, xor_fold or dummy");
  end
  if ((KEY_WIDTH % 32) != 0 || KEY_WIDTH < 32) begin : g_err_key
    $error("calc_hash_pipe: KEY_WIDTH must be a non-zero multiple of 32");
  end
  if (BUCKET_WIDTH < 1 || BUCKET_WIDTH > 32) begin : g_err_bucket
    $error("calc_hash_pipe: BUCKET_WIDTH must be in 1..32");
  end
  if (HT == HT_DUMMY && BUCKET_WIDTH > KEY_WIDTH) begin : g_err_dummy
    $error("calc_hash_pipe: dummy hash needs BUCKET_WIDTH <= KEY_WIDTH");
  end

  // Reflected CRC-32 over one word, byte [31:24] first.
  function automatic logic [31:0] crc_word(input logic [31:0] c_in, input logic [31:0] w);
    logic [31:0] c;
    c = c_in;
    for (int b = 3; b >= 0; b--) begin
      c = c ^ {24'd0, w[8*b +: 8]};
      for (int i = 0; i < 8; i++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] hash_step(input logic [31:0] acc, input logic [31:0] w);
    case (HT)
      HT_CRC:  return crc_word(acc, w);
      HT_XOR:  return acc ^ w;
      default: return acc;
    endcase
  endfunction

  // XOR of all BUCKET_WIDTH slices of the 32-bit value, top slice zero-padded.
  function automatic logic [BUCKET_WIDTH-1:0] fold(input logic [31:0] v);
    logic [PW-1:0]           p;
    logic [BUCKET_WIDTH-1:0] r;
    p       = '0;
    p[31:0] = v;
    r       = '0;
    for (int i = 0; i < NS; i++) begin
      r = r ^ p[i*BUCKET_WIDTH +: BUCKET_WIDTH];
    end
    return r;
  endfunction

  function automatic logic [BUCKET_WIDTH-1:0] bucket_of(input logic [31:0] acc,
                                                         input logic [KEY_WIDTH-1:0] key);
    case (HT)
      HT_CRC:  return acc[31 -: BUCKET_WIDTH];
      HT_XOR:  return fold(acc);
      default: return key[KEY_WIDTH-1 -: BUCKET_WIDTH];
    endcase
  endfunction

  // Stage state.
  logic                  valid_q [NW];
  logic [KEY_WIDTH-1:0]  key_q   [NW];
  logic [SIDE_WIDTH-1:0] side_q  [NW];
  logic [31:0]           acc_q   [NW];
  logic [NW-1:0]         ready_s;

  // Source feeding stage 0 (either the raw input or the skid FIFO head).
  logic                  front_valid;
  logic [KEY_WIDTH-1:0]  front_key;
  logic [SIDE_WIDTH-1:0] front_side;

  // Ready chain: a stage can load when it is empty or everything downstream can move.
  always_comb begin
    logic r;
    ready_s = '0;
    r       = out_ready_i;
    for (int k = NW - 1; k >= 0; k--) begin
      r          = r || !valid_q[k];
      ready_s[k] = r;
    end
  end

  for (genvar gi = 0; gi < NW; gi++) begin : g_stage
    logic                  src_valid;
    logic [KEY_WIDTH-1:0]  src_key;
    logic [SIDE_WIDTH-1:0] src_side;
    logic [31:0]           src_acc;
    logic [31:0]           acc_d;

    if (gi == 0) begin : g_first
      assign src_valid = front_valid;
      assign src_key   = front_key;
      assign src_side  = front_side;
      assign src_acc   = (HT == HT_CRC) ? 32'hFFFF_FFFF : 32'h0;
    end else begin : g_next
      assign src_valid = valid_q[gi-1];
      assign src_key   = key_q[gi-1];
      assign src_side  = side_q[gi-1];
      assign src_acc   = acc_q[gi-1];
    end

    // Fold this stage's key word in; the last stage also applies the CRC output inversion.
    always_comb begin
      acc_d = hash_step(src_acc, src_key[32*(NW-1-gi) +: 32]);
      if ((gi == NW - 1) && (HT == HT_CRC)) begin
        acc_d = acc_d ^ 32'hFFFF_FFFF;
      end
    end

    // Stage register: take the predecessor's beat (or a bubble) whenever this stage may move.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q[gi] <= 1'b0;
        key_q[gi]   <= '0;
        side_q[gi]  <= '0;
        acc_q[gi]   <= '0;
      end else if (ready_s[gi]) begin
        valid_q[gi] <= src_valid;
        if (src_valid) begin
          key_q[gi]  <= src_key;
          side_q[gi] <= src_side;
          acc_q[gi]  <= acc_d;
        end
      end
    end
  end

  if (PIPELINE_READY == 0) begin : g_direct
    assign front_valid = in_valid_i;
    assign front_key   = in_key_i;
    assign front_side  = in_side_i;
    assign in_ready_o  = ready_s[0];
  end else begin : g_skid
    logic [KEY_WIDTH-1:0]  fifo_key_q  [2];
    logic [SIDE_WIDTH-1:0] fifo_side_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic                  in_ready_q;
    logic                  enq;
    logic                  deq;

    assign enq     = in_valid_i && in_ready_q;
    assign deq     = (count_q != 2'd0) && ready_s[0];
    assign count_d = count_q + {1'b0, enq} - {1'b0, deq};

    // FIFO bookkeeping; in_ready is registered from the next occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        count_q    <= 2'd0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
        in_ready_q <= 1'b1;
      end else begin
        count_q    <= count_d;
        wr_ptr_q   <= wr_ptr_q ^ enq;
        rd_ptr_q   <= rd_ptr_q ^ deq;
        in_ready_q <= (count_d != 2'd2);
      end
    end

    // FIFO payload storage; contents are only meaningful while counted.
    always_ff @(posedge clk_i) begin
      if (enq) begin
        fifo_key_q[wr_ptr_q]  <= in_key_i;
        fifo_side_q[wr_ptr_q] <= in_side_i;
      end
    end

    assign front_valid = (count_q != 2'd0);
    assign front_key   = fifo_key_q[rd_ptr_q];
    assign front_side  = fifo_side_q[rd_ptr_q];
    assign in_ready_o  = in_ready_q;
  end

  assign out_valid_o  = valid_q[NW-1];
  assign out_key_o    = key_q[NW-1];
  assign out_side_o   = side_q[NW-1];
  assign out_bucket_o = bucket_of(acc_q[NW-1], key_q[NW-1]);

endmodule
